// File: rtl/fmdll_pkg.sv
// fmdll_pkg: ratio codes, FSM states and ratio helpers shared by the DIV_M generator
package fmdll_pkg;
  localparam logic [1:0] M_DIV4   = 2'd0;
  localparam logic [1:0] M_BYPASS = 2'd1;
  localparam logic [1:0] M_DIV2   = 2'd2;
  localparam logic [1:0] M_DIV3   = 2'd3;
  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
  function automatic logic [2:0] m2n(input logic [1:0] m);
    return (m == M_DIV4) ? 3'd4 : (m == M_BYPASS) ? 3'd1 : {1'b0, m};
  endfunction
  function automatic logic [2:0] ceil_half(input logic [2:0] n);
    return (n + 3'd1) >> 1;
  endfunction
endpackage

// File: rtl/fmdll_sync2.sv
// fmdll_sync2: multi-stage synchronizer for the 2-bit ratio code, resets to bypass
module fmdll_sync2
  import fmdll_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_d,
  output logic [1:0] o_q
);
  logic [STAGES-1:0][1:0] r_sync;
  // shift the raw code through STAGES flops
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sync <= {STAGES{M_BYPASS}};
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/div_m_gen.sv
// div_m_gen: programmable divide-by-M clock generator with glitch-free ratio switching.
// Optional build macro FMDLL_DIVM_CNT_EN adds the period_cnt output.
module div_m_gen
  import fmdll_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_PERIODS = 4,
  parameter int SETTLE_W       = 3
) (
  input  logic       clk_ext,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] M,
  output logic       DIV_M,
  output logic [1:0] m_active,
  output logic       m_chg_pend,
  output logic       div_valid
`ifdef FMDLL_DIVM_CNT_EN
  ,
  output logic [7:0] period_cnt
`endif
);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX  = SETTLE_W'(SETTLE_PERIODS);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_PERIODS - 1);
  state_t              r_state;
  logic [1:0]          r_cnt;
  logic [SETTLE_W-1:0] r_settle;
  logic [1:0]          w_m_sync;
  logic [1:0]          w_cnt_inc;
  logic [2:0]          w_n;
  logic [2:0]          w_n_sync;
  logic                w_wrap;
  logic                w_restart;

  fmdll_sync2 #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk  (clk_ext),
    .i_rst_n(rst_n),
    .i_d    (M),
    .o_q    (w_m_sync)
  );

  assign w_n       = m2n(m_active);
  assign w_n_sync  = m2n(w_m_sync);
  assign w_cnt_inc = r_cnt + 2'd1;
  // bypass keeps cnt at 0 with N-1 == 0, so every edge is a wrap
  assign w_wrap    = ({1'b0, r_cnt} == w_n - 3'd1);
  // leaving IDLE and applying a new ratio both start a fresh period at cnt 0
  assign w_restart = (r_state == IDLE) || (w_wrap && (w_m_sync != m_active));

  // FSM, period counter, settle counter and all registered outputs
  always_ff @(posedge clk_ext or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_settle   <= '0;
      DIV_M      <= 1'b0;
      m_active   <= M_BYPASS;
      m_chg_pend <= 1'b0;
      div_valid  <= 1'b0;
    end else if (!en) begin
      r_state    <= IDLE;
      r_cnt      <= 2'(w_n_sync - 3'd1);
      r_settle   <= '0;
      DIV_M      <= 1'b0;
      m_active   <= w_m_sync;
      m_chg_pend <= 1'b0;
      div_valid  <= 1'b0;
    end else if (w_restart) begin
      r_state    <= SETTLE;
      r_cnt      <= '0;
      r_settle   <= '0;
      DIV_M      <= (w_n_sync != 3'd1);
      m_active   <= w_m_sync;
      m_chg_pend <= 1'b0;
      div_valid  <= 1'b0;
    end else begin
      m_chg_pend <= (w_m_sync != m_active);
      r_cnt      <= w_wrap ? 2'd0 : w_cnt_inc;
      DIV_M      <= w_wrap ? (w_n != 3'd1) : ({1'b0, w_cnt_inc} < ceil_half(w_n));
      if (w_wrap && r_state == SETTLE) begin
        r_settle  <= (r_settle == SETTLE_LAST) ? SETTLE_MAX : r_settle + SETTLE_W'(1);
        r_state   <= (r_settle == SETTLE_LAST) ? LOCKED : SETTLE;
        div_valid <= (r_settle == SETTLE_LAST);
      end
    end

`ifdef FMDLL_DIVM_CNT_EN
  logic [7:0] r_period;
  // completed periods since the current ratio started, free-running modulo 256
  always_ff @(posedge clk_ext or negedge rst_n)
    if (!rst_n)                r_period <= '0;
    else if (!en || w_restart) r_period <= '0;
    else if (w_wrap)           r_period <= r_period + 8'd1;
  assign period_cnt = r_period;
`endif
endmodule
